conv_out_packer: RTL
====================

// Module: conv_out_packer
// PURPOSE
//  Downstream stage of the 3x3 kernel convolution. Takes convolved 8-bit pixels (valid-only, no stall),
//  buffers them and packs 4 pixels per 32-bit word onto an AXI4-Stream master toward the DMA S2MM channel.
//  Absorbs the convolution pipeline's in-flight pixels when the DMA deasserts ready.
//  Drives an almost-full flag back to pixel control so the input side can pause.
// PARAMETERS
//  PIXEL_WIDTH        8    bits per convolved pixel
//  DATA_WIDTH         32   output word width; PIXELS_PER_WORD = DATA_WIDTH/PIXEL_WIDTH = 4
//  FIFO_DEPTH         16   word FIFO depth, power of 2
//  ALMOST_FULL_LEVEL  8    word count at or above which o_almost_full is asserted
//  LINE_PIXELS        320  output pixels per line, multiple of PIXELS_PER_WORD
//  FRAME_LINES        240  lines per frame; used only with CONV_OUT_TLAST_EN
// PORTS
//  axi_clock      in   1           single clock, all logic on the rising edge
//  axi_resetn     in   1           asynchronous assert, active-low reset
//  i_pixel        in   PIXEL_WIDTH convolved pixel
//  i_pixel_valid  in   1           i_pixel valid this cycle; no backpressure possible
//  o_almost_full  out  1           FIFO count >= ALMOST_FULL_LEVEL
//  o_overflow     out  1           sticky: a packed word was dropped
//  o_data         out  DATA_WIDTH  AXIS tdata; first pixel of the word in bits [7:0]
//  o_data_valid   out  1           AXIS tvalid
//  i_data_ready   in   1           AXIS tready from DMA
//  o_data_last    out  1           AXIS tlast, last word of frame; tied 0 without the macro
//  o_frame_done   out  1           1-cycle pulse when the tlast word handshakes; 0 without the macro
// BEHAVIOUR
//  - Reset: all outputs 0; lane counter, FIFO pointers/count, line/pixel counters cleared; partial word discarded.
//  - Packing: 2-bit lane counter. A pixel with lane<3 goes into shift register lane slot; lane++.
//    A pixel with lane==3 forms {pixel, slot2, slot1, slot0}; this word is written to the FIFO on the same edge (edge k); lane->0.
//  - Latency: a word written at edge k is visible on o_data/o_data_valid after edge k+1 (registered FWFT output stage).
//  - AXIS rules: transfer = o_data_valid & i_data_ready. While valid & !ready, o_data/o_data_last are held stable.
//    Valid is never withdrawn before a transfer. Back-to-back transfers: one word per cycle when ready stays high.
//  - Full: write while count==FIFO_DEPTH and no read on the same edge -> word dropped, o_overflow=1 until reset.
//    Lane counter still advances. Write and read on the same edge when full -> accepted, count unchanged.
//  - Empty: read never occurs while empty; o_data_valid=0.
//  - count is updated +1/-1/0 per edge; o_almost_full is registered from the next count value (no extra lag).
//  - Pointers wrap modulo FIFO_DEPTH.
//  - Reset mid-frame: everything returns to reset state immediately (async). A word held on o_data is lost.
// CONFIGURATION
//  - CONV_OUT_TLAST_EN defined:
//    - Word counter (0..LINE_PIXELS/4-1) and line counter (0..FRAME_LINES-1) advance on each FIFO write, including dropped words.
//    - The last word of the last line carries last=1 through the FIFO (FIFO width DATA_WIDTH+1).
//    - o_frame_done pulses on its handshake. Both counters wrap to 0 after the frame.
//  - Not defined: counters and last bit removed; FIFO width DATA_WIDTH; o_data_last=0 and o_frame_done=0.
// STRUCTURE
//  - Shared package img_core_pkg: PIXEL_WIDTH, PIXELS_PER_WORD, and the pixel_t/word_t typedefs,
//    also shared with the pixel control and kernel convolution stages.
//  - Sub-module sync_word_fifo: parameterised width/depth, FWFT, count output, simultaneous rd/wr when full.
//  - Packing, counters and flags live in conv_out_packer.
// TESTING
//  1. Reset, then pixels 0x11,0x22,0x33,0x44 on consecutive cycles with ready=1
//     -> one transfer o_data=0x44332211, valid 1 cycle after the write edge.
//  2. ready=0, 40 pixels streamed -> 10 words stored; o_almost_full rises when count reaches 8.
//     Release ready -> 10 in-order transfers; data stays stable while stalled.
//  3. ready=0, 17 words (68 pixels) -> o_overflow=1 on the 17th; first 16 words come out intact; o_overflow stays 1.
//  4. Count=16 with ready=1 and a write on the same edge -> no overflow, count stays 16.
//  5. CONV_OUT_TLAST_EN, LINE_PIXELS=8, FRAME_LINES=2, 16 pixels -> o_data_last only on the 4th word;
//     o_frame_done pulses once; the next frame repeats the same pattern.
//  6. axi_resetn low after 2 pixels of a word, then 4 new pixels -> exactly one word formed from the new pixels only.

Source files
------------

// File: rtl/img_core_pkg.sv
// Shared image-pipeline types: pixel/word widths and typedefs used by the pixel control,
// kernel convolution and output packing stages.
package img_core_pkg;

    localparam int unsigned PIXEL_WIDTH     = 8;
    localparam int unsigned DATA_WIDTH      = 32;
    localparam int unsigned PIXELS_PER_WORD = DATA_WIDTH / PIXEL_WIDTH;
    localparam int unsigned LANE_WIDTH      = $clog2(PIXELS_PER_WORD);

    typedef logic [PIXEL_WIDTH-1:0] pixel_t;
    typedef logic [DATA_WIDTH-1:0]  word_t;
    typedef logic [LANE_WIDTH-1:0]  lane_t;

endpackage

// File: rtl/conv_out_packer_if.sv
// Pixel input, flow-control flags and AXI4-Stream output of the convolution output packer.
// master: the packer's view; slave: the surrounding pipeline / DMA view.
interface conv_out_packer_if;
    import img_core_pkg::*;

    pixel_t i_pixel;
    logic   i_pixel_valid;
    logic   o_almost_full;
    logic   o_overflow;
    word_t  o_data;
    logic   o_data_valid;
    logic   i_data_ready;
    logic   o_data_last;
    logic   o_frame_done;

    modport master (
        input  i_pixel, i_pixel_valid, i_data_ready,
        output o_almost_full, o_overflow, o_data, o_data_valid, o_data_last, o_frame_done
    );

    modport slave (
        output i_pixel, i_pixel_valid, i_data_ready,
        input  o_almost_full, o_overflow, o_data, o_data_valid, o_data_last, o_frame_done
    );

endinterface

// File: rtl/sync_word_fifo.sv
// Single-clock first-word-fall-through FIFO with a registered output stage. count covers the
// memory and the output register; a write is accepted when full if a read happens on that edge.
module sync_word_fifo #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 16,
    localparam int unsigned PTR_W = $clog2(DEPTH),
    localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             rd_valid,
    output logic [CNT_W-1:0] count,
    output logic [CNT_W-1:0] count_next
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] count_q, count_d;
    logic [WIDTH-1:0] dout_q;
    logic             dout_vld_q;

    logic rd_fire, full, wr_accept, mem_avail, pop;

    assign rd_fire   = rd_en && dout_vld_q;
    assign full      = (count_q == CNT_W'(DEPTH));
    assign wr_accept = wr_en && (!full || rd_fire);
    // Words still in memory; a word written this edge is not eligible until the next one.
    assign mem_avail = (count_q > CNT_W'(dout_vld_q));
    assign pop       = mem_avail && (!dout_vld_q || rd_fire);
    assign count_d   = count_q + CNT_W'(wr_accept) - CNT_W'(rd_fire);

    always_ff @(posedge clk) begin
        if (wr_accept) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            dout_q     <= '0;
            dout_vld_q <= 1'b0;
        end else begin
            count_q <= count_d;
            if (wr_accept) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_q   <= rd_ptr_q + PTR_W'(1);
                dout_q     <= mem_q[rd_ptr_q];
                dout_vld_q <= 1'b1;
            end else if (rd_fire) begin
                dout_vld_q <= 1'b0;
            end
        end
    end

    assign rd_data    = dout_q;
    assign rd_valid   = dout_vld_q;
    assign count      = count_q;
    assign count_next = count_d;

endmodule

// File: rtl/conv_out_packer.sv
// Packs 4 convolved pixels per 32-bit word into a FIFO feeding an AXI4-Stream master.
// Optional frame tlast/frame_done generation is enabled by defining CONV_OUT_TLAST_EN.
module conv_out_packer
    import img_core_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH        = 16,
    parameter int unsigned ALMOST_FULL_LEVEL = 8,
    parameter int unsigned LINE_PIXELS       = 320,
    parameter int unsigned FRAME_LINES       = 240
) (
    input  logic              axi_clock,
    input  logic              axi_resetn,
    conv_out_packer_if.master bus
);

    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 ||
        (LINE_PIXELS % PIXELS_PER_WORD) != 0 || LINE_PIXELS == 0 || FRAME_LINES == 0 ||
        ALMOST_FULL_LEVEL > FIFO_DEPTH) begin : g_cfg_err
        $error("conv_out_packer: invalid parameter set");
    end

`ifdef CONV_OUT_TLAST_EN
    localparam int unsigned FIFO_W = DATA_WIDTH + 1;
`else
    localparam int unsigned FIFO_W = DATA_WIDTH;
`endif
    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);

    lane_t                         lane_q;
    pixel_t [PIXELS_PER_WORD-2:0]  slot_q;
    logic                          word_wr;
    word_t                         word;
    logic [FIFO_W-1:0]             fifo_wdata, fifo_rdata;
    logic [CNT_W-1:0]              fifo_count, fifo_count_next;
    logic                          xfer, word_drop;
    logic                          almost_full_q, overflow_q;

    assign word_wr = bus.i_pixel_valid && (lane_q == lane_t'(PIXELS_PER_WORD - 1));
    assign word    = {bus.i_pixel, slot_q};
    assign xfer    = bus.o_data_valid && bus.i_data_ready;
    assign word_drop = word_wr && (fifo_count == CNT_W'(FIFO_DEPTH)) && !xfer;

    always_ff @(posedge axi_clock or negedge axi_resetn) begin
        if (!axi_resetn) begin
            lane_q <= '0;
            slot_q <= '0;
        end else if (bus.i_pixel_valid) begin
            lane_q <= lane_q + lane_t'(1);
            if (!word_wr) begin
                slot_q[lane_q] <= bus.i_pixel;
            end
        end
    end

    always_ff @(posedge axi_clock or negedge axi_resetn) begin
        if (!axi_resetn) begin
            almost_full_q <= 1'b0;
            overflow_q    <= 1'b0;
        end else begin
            almost_full_q <= (32'(fifo_count_next) >= ALMOST_FULL_LEVEL);
            overflow_q    <= overflow_q || word_drop;
        end
    end

`ifdef CONV_OUT_TLAST_EN
    localparam int unsigned WORDS_PER_LINE = LINE_PIXELS / PIXELS_PER_WORD;
    localparam int unsigned WCNT_W = (WORDS_PER_LINE > 1) ? $clog2(WORDS_PER_LINE) : 1;
    localparam int unsigned LCNT_W = (FRAME_LINES > 1) ? $clog2(FRAME_LINES) : 1;

    logic [WCNT_W-1:0] word_cnt_q;
    logic [LCNT_W-1:0] line_cnt_q;
    logic              last_word, last_line;

    assign last_word = (word_cnt_q == WCNT_W'(WORDS_PER_LINE - 1));
    assign last_line = (line_cnt_q == LCNT_W'(FRAME_LINES - 1));

    // Counters follow every formed word, dropped or not, so frame position stays aligned.
    always_ff @(posedge axi_clock or negedge axi_resetn) begin
        if (!axi_resetn) begin
            word_cnt_q <= '0;
            line_cnt_q <= '0;
        end else if (word_wr) begin
            if (last_word) begin
                word_cnt_q <= '0;
                line_cnt_q <= last_line ? '0 : line_cnt_q + LCNT_W'(1);
            end else begin
                word_cnt_q <= word_cnt_q + WCNT_W'(1);
            end
        end
    end

    assign fifo_wdata       = {last_word && last_line, word};
    assign {bus.o_data_last, bus.o_data} = fifo_rdata;
    assign bus.o_frame_done = xfer && bus.o_data_last;
`else
    assign fifo_wdata       = word;
    assign bus.o_data       = fifo_rdata;
    assign bus.o_data_last  = 1'b0;
    assign bus.o_frame_done = 1'b0;
`endif

    sync_word_fifo #(
        .WIDTH (FIFO_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk        (axi_clock),
        .rst_n      (axi_resetn),
        .wr_en      (word_wr),
        .wr_data    (fifo_wdata),
        .rd_en      (bus.i_data_ready),
        .rd_data    (fifo_rdata),
        .rd_valid   (bus.o_data_valid),
        .count      (fifo_count),
        .count_next (fifo_count_next)
    );

    assign bus.o_almost_full = almost_full_q;
    assign bus.o_overflow    = overflow_q;

endmodule
